encoder10_4: RTL
================

# encoder10_4

Keypad-side 10-to-4 encoder: the inverse of the team's 4-to-10 decoder. Samples ten raw active-high key lines, synchronizes and debounces them, and converts a stable one-hot pattern into its 4-bit index. Each accepted press is delivered exactly once over a valid/ready handshake. Invalid patterns (multi-hot) are rejected with an error pulse. Sits between the board key inputs and the digit-processing datapath.

## Interface
- DB_CYCLES, default 4: consecutive stable cycles required for both press and release debounce; legal range ≥ 2.
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  detect enable; gates the start of new presses only.
- din  in  10  raw key lines, active-high; bit i is key i.
- dout  out  4  encoded key index 0..9.
- out_valid  out  1  dout holds a new key code.
- out_ready  in  1  consumer accepts dout when out_valid && out_ready at a rising edge.
- multi_err  out  1  one-cycle pulse: stable multi-hot pattern rejected.

## Operation
- 2-flop synchronizer on din produces s_din. Reset clears both flops to 0.
- Counter cnt has width $clog2(DB_CYCLES). cap is a 10-bit pattern register.
- FSM states and transitions:
  - IDLE: if en && s_din != 0, go to DEBOUNCE; cap <= s_din, cnt <= 0.
  - DEBOUNCE, s_din == 0 or en == 0: go to IDLE.
  - DEBOUNCE, s_din != cap (nonzero): restart; cap <= s_din, cnt <= 0.
  - DEBOUNCE, s_din == cap and cnt < DB_CYCLES-1: cnt++.
  - DEBOUNCE, s_din == cap and cnt == DB_CYCLES-1, cap one-hot: dout <= index of the set bit, out_valid <= 1, go to OUTPUT.
  - DEBOUNCE, s_din == cap and cnt == DB_CYCLES-1, cap multi-hot: multi_err <= 1 for one cycle, go to RELEASE. No out_valid.
  - OUTPUT: hold out_valid and dout stable. On out_valid && out_ready: out_valid <= 0, go to RELEASE, cnt <= 0. Neither en nor din affects OUTPUT.
  - RELEASE: if s_din != 0, cnt <= 0. Otherwise cnt++. When cnt == DB_CYCLES-1 with s_din == 0, go to IDLE. en is ignored.
- One press produces exactly one transfer, no matter how long the key is held.
- A press of a different key while in OUTPUT or RELEASE is ignored. The block waits for full release first.
- out_valid never drops without a completed transfer, except on rst.
- Illegal state encodings return to IDLE.

## Timing
- Reset values, applied at the first rising edge with rst=1: dout=0, out_valid=0, multi_err=0, sync flops=0, cap=0, cnt=0, state=IDLE.
- rst dominates every other input in every state. This includes mid-OUTPUT, where the pending code is discarded.
- Press latency: let E be the first edge that samples a stable pattern into the synchronizer. DEBOUNCE is entered at edge E+2. out_valid (or multi_err) is asserted after edge E+DB_CYCLES+2, i.e. E+6 at default.
- Transfer occurs on the edge where out_valid && out_ready. out_valid is low in the following cycle.
- Release: after the edge where s_din first reads 0 in RELEASE, it takes DB_CYCLES edges of continuous zero to return to IDLE. The earliest next press is detected one edge later.
- multi_err is high for exactly one cycle per rejected press.

## Test plan
- Single key (DB_CYCLES=4, out_ready=1): din=10'b00_0010_0000 held 20 cycles, then 0. Expect out_valid high for one cycle after edge E+6 with dout=5, and no second transfer. The FSM returns to IDLE.
- Backpressure: din=10'b10_0000_0000 held, out_ready=0 for 10 cycles. Expect out_valid=1 and dout=9 held stable throughout. Then out_ready=1: exactly one transfer, and out_valid=0 on the next cycle.
- Bounce: din alternates 0x001/0x000 every 2 cycles for 12 cycles, then holds 0x001. Expect no output during bouncing, then exactly one dout=0 at 6 edges after stabilization.
- Multi-hot: din=0x003 held. Expect one multi_err pulse and no out_valid. Release for 5 cycles, then press din=0x008: expect dout=3.
- Reset mid-OUTPUT: key 7 in OUTPUT with out_ready=0; rst=1 for one edge. Expect all outputs 0 on the next cycle. With key 7 still held and rst=0, expect re-detection with dout=7 after the full latency from the synchronizer onward.
- Enable gating: en=0 while pressing key 4 → no output. Then en=1 with the key held → detection and dout=4. Set en=0 in OUTPUT → out_valid stays held until out_ready.

Source files
------------

// File: rtl/encoder10_4.sv
`default_nettype none
// ============================================================================
//  Module      : encoder10_4
//  Description : Keypad-side 10-to-4 encoder. Synchronizes and debounces ten
//                raw active-high key lines, converts a stable one-hot pattern
//                into its 4-bit index and delivers each press exactly once
//                over a valid/ready handshake. Stable multi-hot patterns are
//                rejected with a one-cycle error pulse.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                en         - detect enable (gates the start of new presses)
//                din[9:0]   - raw key lines, bit i is key i
//                dout[3:0]  - encoded key index 0..9
//                out_valid  - dout holds a new key code
//                out_ready  - consumer accepts dout on out_valid && out_ready
//                multi_err  - one-cycle pulse, multi-hot pattern rejected
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder10_4 #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [9:0] din,
    output logic [3:0] dout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       multi_err
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DB_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_ST_OUTPUT   = 2'd2;
    localparam logic [1:0] c_ST_RELEASE  = 2'd3;

    // Synchronizer; r_s_din is the metastability-safe view of the keys.
    logic [9:0]       r_sync1;
    logic [9:0]       r_s_din;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       r_cap;
    logic [3:0]       r_dout;
    logic             r_out_valid;
    logic             r_multi_err;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [9:0]       w_cap_nxt;
    logic [3:0]       w_dout_nxt;
    logic             w_valid_nxt;
    logic             w_err_nxt;

    logic             w_onehot;
    logic [3:0]       w_idx;

    // A nonzero value with no bit left after clearing its lowest set bit.
    assign w_onehot = (r_cap != 10'd0) && ((r_cap & (r_cap - 10'd1)) == 10'd0);

    // Index of the set bit; only consumed when w_onehot is true.
    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_cap[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 10'd0;
            r_s_din <= 10'd0;
        end else begin
            r_sync1 <= din;
            r_s_din <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_cap       <= 10'd0;
            r_dout      <= 4'd0;
            r_out_valid <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cap       <= w_cap_nxt;
            r_dout      <= w_dout_nxt;
            r_out_valid <= w_valid_nxt;
            r_multi_err <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap_nxt   = r_cap;
        w_dout_nxt  = r_dout;
        w_valid_nxt = r_out_valid;
        w_err_nxt   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_valid_nxt = 1'b0;
                if (en && (r_s_din != 10'd0)) begin
                    w_state_nxt = c_ST_DEBOUNCE;
                    w_cap_nxt   = r_s_din;
                    w_cnt_nxt   = '0;
                end
            end

            c_ST_DEBOUNCE: begin
                if ((r_s_din == 10'd0) || !en) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_s_din != r_cap) begin
                    // A different pattern restarts the stability window.
                    w_cap_nxt = r_s_din;
                    w_cnt_nxt = '0;
                end else if (r_cnt != c_CNT_LAST) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else if (w_onehot) begin
                    w_dout_nxt  = w_idx;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = c_ST_OUTPUT;
                end else begin
                    // Rejected press still has to be released before the
                    // next one; start the release window from zero.
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_RELEASE;
                end
            end

            c_ST_OUTPUT: begin
                if (r_out_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_RELEASE;
                end
            end

            c_ST_RELEASE: begin
                if (r_s_din != 10'd0) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign dout      = r_dout;
    assign out_valid = r_out_valid;
    assign multi_err = r_multi_err;

endmodule
`default_nettype wire
